// File: rtl/uart_cfg_rx_if.sv
// Handshake bundle between the host serial line, the frame receiver and the control core.
interface uart_cfg_rx_if;
  logic        RX;
  logic        clr_rdy;
  logic [23:0] cfg_data;
  logic        frm_rdy;
  logic        frm_err;
  logic        ovr;

  modport master (
    output RX,
    output clr_rdy,
    input  cfg_data,
    input  frm_rdy,
    input  frm_err,
    input  ovr
  );

  modport slave (
    input  RX,
    input  clr_rdy,
    output cfg_data,
    output frm_rdy,
    output frm_err,
    output ovr
  );
endinterface

// File: rtl/uart_cfg_rx.sv
// 8N1 receiver that packs three bytes into one 24-bit configuration word with a ready/clear handshake.
// state | meaning
// IDLE  | line idle or held low, waiting for a falling edge
// START | confirming the start bit at its midpoint
// DATA  | shifting in 8 data bits, LSB first
// STOP  | checking the stop bit, then filing the byte
module uart_cfg_rx #(
  parameter int BAUD_DIV     = 1302,
  parameter int TIMEOUT_BITS = 20
) (
  input logic         clk,
  input logic         rst,
  uart_cfg_rx_if.slave bus
);

  localparam int CW       = $clog2(BAUD_DIV);
  localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int IW       = $clog2(TO_LIMIT + 1);

  localparam logic [CW-1:0] HALF_CNT = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] TO_MAX   = IW'(TO_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic [1:0]    byte_cnt;
  logic [7:0]    byte0, byte1;
  logic [IW-1:0] idle_cnt;
  logic [23:0]   cfg_q;
  logic          rdy_q, err_q, ovr_q;

  logic cnt_clr, shift_en, stop_ok, stop_bad;
  logic frame_done, timed_out;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_nxt = START;
          cnt_clr   = 1'b1;
        end
      end
      START: begin
        if (cnt == HALF_CNT) begin
          cnt_clr   = 1'b1;
          state_nxt = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_CNT) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_CNT) begin
          cnt_clr   = 1'b1;
          state_nxt = IDLE;
          stop_ok   = rx_sync;
          stop_bad  = !rx_sync;
        end
      end
    endcase
  end

  assign frame_done = stop_ok && (byte_cnt == 2'd2);
  assign timed_out  = (state == IDLE) && (idle_cnt == TO_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      byte_cnt  <= '0;
      byte0     <= '0;
      byte1     <= '0;
      idle_cnt  <= '0;
      cfg_q     <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta <= bus.RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;

      if (cnt_clr || state == IDLE) cnt <= '0;
      else                          cnt <= cnt + 1'b1;

      if (state != DATA)  bit_idx <= '0;
      else if (shift_en)  bit_idx <= bit_idx + 3'd1;

      if (shift_en) shift_reg <= {rx_sync, shift_reg[7:1]};

      // Leaving IDLE zeroes the counter so every IDLE visit starts a fresh timeout.
      if (state != IDLE)          idle_cnt <= '0;
      else if (idle_cnt != TO_MAX) idle_cnt <= idle_cnt + 1'b1;

      err_q <= stop_bad;
      ovr_q <= 1'b0;

      if (stop_bad) begin
        byte_cnt <= '0;
      end else if (stop_ok) begin
        if (byte_cnt == 2'd0) byte0 <= shift_reg;
        if (byte_cnt == 2'd1) byte1 <= shift_reg;
        if (frame_done) begin
          cfg_q    <= {byte0, byte1, shift_reg};
          ovr_q    <= rdy_q && !bus.clr_rdy;
          byte_cnt <= '0;
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
        end
      end else if (timed_out && byte_cnt != 2'd0) begin
        byte_cnt <= '0;
      end

      // A completing frame takes priority over a simultaneous clear.
      if (frame_done)       rdy_q <= 1'b1;
      else if (bus.clr_rdy) rdy_q <= 1'b0;
    end
  end

  assign bus.cfg_data = cfg_q;
  assign bus.frm_rdy  = rdy_q;
  assign bus.frm_err  = err_q;
  assign bus.ovr      = ovr_q;

endmodule
